// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one imem fetch in flight, and feeds IF/ID through an output slot plus a one-entry buffer.
// Optional misaligned-redirect trap: define IF_MISALIGN_CHK_EN.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        fault_o
);

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] S_REQ  = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_FULL = 3'd2;
  localparam logic [2:0] S_DROP = 3'd3;
  localparam logic [2:0] S_HALT = 3'd4;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } if_entry_t;

  logic [2:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            req_q, req_d;
  if_entry_t       slot_q, slot_d;
  logic            valid_q, valid_d;
  logic            fault_q, fault_d;
  if_entry_t       buf_q, buf_d;
  logic            buf_v_q, buf_v_d;

  logic            gnt_ok;
  logic            drain;
  logic            misalign;
  logic [XLEN-1:0] redir_pc;

  // A grant only counts while a request is actually presented.
  assign gnt_ok = req_q & imem_gnt;
  assign drain  = valid_q & ready_i;

`ifdef IF_MISALIGN_CHK_EN
  assign redir_pc = redirect_pc_i;
  assign misalign = |redirect_pc_i[1:0];
`else
  assign redir_pc = redirect_pc_i & ~XLEN'(3);
  assign misalign = 1'b0;
`endif

  // Next-state and datapath decode; redirect is applied last so it overrides drain/load.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    slot_d  = slot_q;
    valid_d = valid_q;
    fault_d = fault_q;
    buf_d   = buf_q;
    buf_v_d = buf_v_q;
    req_d   = 1'b0;

    if (drain) begin
      valid_d      = 1'b0;
      fault_d      = 1'b0;
      slot_d.instr = NOP_INSTR;
    end

    case (state_q)
      S_REQ: begin
        if (gnt_ok) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          pc_d = pc_q + XLEN'(4);
          if (!valid_q || drain) begin
            slot_d  = '{instr: imem_rdata, pc: pc_q};
            valid_d = 1'b1;
            state_d = S_REQ;
          end else begin
            buf_d   = '{instr: imem_rdata, pc: pc_q};
            buf_v_d = 1'b1;
            state_d = S_FULL;
          end
        end
      end
      S_FULL: begin
        if (drain && buf_v_q) begin
          slot_d  = buf_q;
          valid_d = 1'b1;
          buf_v_d = 1'b0;
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        if (imem_rvalid) state_d = S_REQ;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_REQ;
      end
    endcase

    if (redirect_i) begin
      valid_d      = 1'b0;
      fault_d      = 1'b0;
      slot_d.instr = NOP_INSTR;
      buf_v_d      = 1'b0;
      pc_d         = redir_pc;
      // A response still owed by memory must be swallowed before refetching.
      case (state_q)
        S_REQ:   state_d = gnt_ok ? S_DROP : S_REQ;
        S_WAIT:  state_d = imem_rvalid ? S_REQ : S_DROP;
        S_DROP:  state_d = imem_rvalid ? S_REQ : S_DROP;
        default: state_d = S_REQ;
      endcase
      if (misalign) begin
        slot_d  = '{instr: NOP_INSTR, pc: redirect_pc_i};
        valid_d = 1'b1;
        fault_d = 1'b1;
        state_d = S_HALT;
      end
    end

    req_d = (state_d == S_REQ);
  end

  // State and data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      slot_q  <= '{instr: NOP_INSTR, pc: '0};
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      buf_q   <= '{instr: NOP_INSTR, pc: '0};
      buf_v_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      slot_q  <= slot_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      buf_q   <= buf_d;
      buf_v_q <= buf_v_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign valid_o   = valid_q;
  assign instr_o   = slot_q.instr;
  assign pc_o      = slot_q.pc;
  assign fault_o   = fault_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: randomized imem/decode/redirect traffic checked every cycle against a
// queue-level model (words held, next PCs to fetch/deliver), plus directed literal checks.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] STALE = 32'hDEAD_BEEF;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        ready_i;
  logic        valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        fault_o;

  if_fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .ready_i       (ready_i),
    .valid_o       (valid_o),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .fault_o       (fault_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Stimulus knobs
  int unsigned gnt_pct, rdy_pct, redir_pct, lat_lo, lat_hi;
  logic        force_redir;
  logic [31:0] force_tgt;

  // Model state
  int          held;
  logic        pending, stale, halted, skip_req;
  int unsigned lat_cnt;
  logic [31:0] resp_addr, exp_fpc, exp_dpc;
  logic [31:0] grant_log[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0050_0093 ^ (a << 5);
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    held = 0; pending = 1'b0; stale = 1'b0; halted = 1'b0; skip_req = 1'b1;
    lat_cnt = 0; resp_addr = '0; exp_fpc = 32'h0; exp_dpc = 32'h0;
    grant_log.delete();
  endtask

  // One clock: check outputs against the model, drive next inputs, advance the model.
  task automatic step();
    logic        gnt_now, rdy_now, rv_now, redir, mis, live_rv, drn;
    logic [31:0] tgt, eff;
    @(negedge clk);
    check1("valid_o", valid_o, held != 0);
    if (held != 0) begin
      check32("pc_o", pc_o, exp_dpc);
      check32("instr_o", instr_o, halted ? NOP : mem_word(exp_dpc));
    end else begin
      check32("instr_idle", instr_o, NOP);
    end
    check1("fault_o", fault_o, halted && (held != 0));
    if (!skip_req) check1("imem_req", imem_req, !pending && (held < 2) && !halted);
    if (imem_req) check32("imem_addr", imem_addr, exp_fpc);
    skip_req = 1'b0;

    gnt_now = imem_req && ($urandom_range(0, 99) < gnt_pct);
    rdy_now = ($urandom_range(0, 99) < rdy_pct);
    rv_now  = 1'b0;
    if (pending) begin
      if (lat_cnt == 0) rv_now = 1'b1;
      else lat_cnt--;
    end
    redir = 1'b0;
    tgt   = $urandom;
    if (force_redir) begin
      redir = 1'b1; tgt = force_tgt; force_redir = 1'b0;
    end else if ($urandom_range(0, 99) < redir_pct) begin
      redir = 1'b1;
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2);
      else tgt = $urandom & 32'h0000_FFFF;
`ifdef IF_MISALIGN_CHK_EN
      if (pending || gnt_now || ($urandom_range(0, 7) != 0)) tgt[1:0] = 2'b00;
`endif
    end
    imem_gnt      = gnt_now;
    imem_rvalid   = rv_now;
    imem_rdata    = rv_now ? (stale ? STALE : mem_word(resp_addr)) : $urandom;
    ready_i       = rdy_now;
    redirect_i    = redir;
    redirect_pc_i = tgt;

    drn     = (held != 0) && rdy_now;
    live_rv = rv_now && !stale;
    if (rv_now) pending = 1'b0;
    if (gnt_now) begin
      pending = 1'b1; stale = 1'b0; resp_addr = imem_addr;
      lat_cnt = $urandom_range(lat_lo, lat_hi);
    end
    if (redir) begin
      if (pending) stale = 1'b1;
`ifdef IF_MISALIGN_CHK_EN
      eff = tgt; mis = (tgt[1:0] != 2'b00);
`else
      eff = {tgt[31:2], 2'b00}; mis = 1'b0;
`endif
      held = mis ? 1 : 0; halted = mis;
      exp_fpc = eff; exp_dpc = eff;
      grant_log.delete();
    end else begin
      if (gnt_now) begin
        grant_log.push_back(imem_addr);
        exp_fpc = exp_fpc + 32'd4;
      end
      held = held + (live_rv ? 1 : 0) - (drn ? 1 : 0);
      if (drn) exp_dpc = exp_dpc + 32'd4;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_i = 1'b0; redirect_pc_i = '0; ready_i = 1'b0;
    gnt_pct = 100; rdy_pct = 100; redir_pct = 0; lat_lo = 0; lat_hi = 0;
    force_redir = 1'b0; force_tgt = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check1("rst_valid", valid_o, 1'b0);
    check32("rst_instr", instr_o, NOP);
    check32("rst_pc", pc_o, 32'h0);
    check1("rst_req", imem_req, 1'b0);
    check1("rst_fault", fault_o, 1'b0);
    rst_n = 1'b1;

    // First fetch at address 0, one-cycle grant/response
    for (int i = 0; i < 8; i++) begin
      step();
      if (imem_req) break;
    end
    check1("t1_req", imem_req, 1'b1);
    check32("t1_addr0", imem_addr, 32'h0);
    rdy_pct = 0;
    step();
    step();
    check1("t1_valid", valid_o, 1'b1);
    check32("t1_instr", instr_o, 32'h0050_0093);
    check32("t1_pc", pc_o, 32'h0);
    check32("t1_addr4", imem_addr, 32'h4);

    // Decode stall: slot + buffer fill, no request while full
    repeat (5) step();
    check1("t2_valid", valid_o, 1'b1);
    check32("t2_pc_hold", pc_o, 32'h0);
    check1("t2_noreq", imem_req, 1'b0);
    rdy_pct = 100; lat_lo = 2; lat_hi = 2;
    step();
    step();
    check32("t2_pc4", pc_o, 32'h4);
    check32("t2_addr8", imem_addr, 32'h8);
    check1("t2_req", imem_req, 1'b1);

    // Redirect while waiting; late stale response must be discarded
    force_redir = 1'b1; force_tgt = 32'h0000_0100;
    step();
    step();
    check1("t3_flush", valid_o, 1'b0);
    check1("t3_drop_noreq", imem_req, 1'b0);
    lat_lo = 0; lat_hi = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (imem_req) break;
    end
    check32("t3_addr", imem_addr, 32'h0000_0100);

    // Redirect coincident with rvalid; grant withheld three cycles
    force_redir = 1'b1; force_tgt = 32'h0000_0200; gnt_pct = 0;
    step();
    repeat (3) begin
      step();
      check1("t4_req", imem_req, 1'b1);
      check32("t4_addr", imem_addr, 32'h0000_0200);
      check1("t4_valid", valid_o, 1'b0);
    end
    gnt_pct = 100;
    step();
    step();
    step();
    check1("t4_valid_out", valid_o, 1'b1);
    check32("t4_pc", pc_o, 32'h0000_0200);
    check32("t4_instr", instr_o, 32'h0050_4093);

    // PC wraparound
    force_redir = 1'b1; force_tgt = 32'hFFFF_FFFC;
    step();
    for (int i = 0; i < 30 && grant_log.size() < 2; i++) step();
    if (grant_log.size() >= 2) begin
      check32("t5_first", grant_log[0], 32'hFFFF_FFFC);
      check32("t5_wrap", grant_log[1], 32'h0000_0000);
    end else begin
      check32("t5_grants", 32'(grant_log.size()), 32'd2);
    end

`ifdef IF_MISALIGN_CHK_EN
    // Misaligned redirect parks with a faulting NOP
    gnt_pct = 0;
    for (int i = 0; i < 20 && pending; i++) step();
    rdy_pct = 0; force_redir = 1'b1; force_tgt = 32'h0000_0102;
    step();
    step();
    check1("t6_noreq", imem_req, 1'b0);
    check1("t6_valid", valid_o, 1'b1);
    check1("t6_fault", fault_o, 1'b1);
    check32("t6_pc", pc_o, 32'h0000_0102);
    check32("t6_instr", instr_o, NOP);
    repeat (3) begin
      step();
      check1("t6_park", imem_req, 1'b0);
    end
    rdy_pct = 100;
    step();
    step();
    check1("t6_fault_clr", fault_o, 1'b0);
    check1("t6_valid_clr", valid_o, 1'b0);
    gnt_pct = 100; force_redir = 1'b1; force_tgt = 32'h0000_0300;
    step();
`else
    // Low target bits are ignored
    force_redir = 1'b1; force_tgt = 32'h0000_0102;
    step();
    for (int i = 0; i < 20; i++) begin
      step();
      if (imem_req) break;
    end
    check32("t6_aligned_addr", imem_addr, 32'h0000_0100);
    check1("t6_nofault", fault_o, 1'b0);
`endif

    // Randomized traffic
    for (int blk = 0; blk < 20; blk++) begin
      gnt_pct   = $urandom_range(30, 100);
      rdy_pct   = $urandom_range(20, 100);
      redir_pct = $urandom_range(0, 6);
      lat_lo    = 0;
      lat_hi    = $urandom_range(0, 4);
      repeat (200) step();
    end

    // Asynchronous reset mid-traffic, then a spurious rvalid at release
    #2 rst_n = 1'b0;
    #1;
    check1("arst_valid", valid_o, 1'b0);
    check1("arst_req", imem_req, 1'b0);
    check32("arst_instr", instr_o, NOP);
    check32("arst_addr", imem_addr, 32'h0);
    @(negedge clk);
    model_reset();
    imem_gnt = 1'b0; redirect_i = 1'b0; ready_i = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = STALE;
    rst_n = 1'b1;
    gnt_pct = 70; rdy_pct = 70; redir_pct = 3; lat_lo = 0; lat_hi = 3;
    repeat (500) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
